// File: rtl/square_root.sv
// square_root: free-running floor square root and remainder, two radicand bits per cycle.
// A new result is published every WORD_LENGTH/2+2 cycles.
module square_root #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] DataInput,
    output logic [WORD_LENGTH-1:0] result,
    output logic [WORD_LENGTH-1:0] residue
);
    localparam int H  = WORD_LENGTH / 2;
    localparam int RW = H + 2;
    localparam int CW = $clog2(H + 1);
    localparam logic [1:0] LOAD   = 2'd0;
    localparam logic [1:0] ITER   = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [WORD_LENGTH-1:0] op_q, op_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [H-1:0]           root_q, root_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WORD_LENGTH-1:0] result_q, result_d;
    logic [WORD_LENGTH-1:0] residue_q, residue_d;
    logic [RW-1:0]          rem_sh, trial;
    logic [H:0]             root_sh;
    logic                   ge;

    always_comb begin
        rem_sh    = {rem_q[RW-3:0], op_q[WORD_LENGTH-1:WORD_LENGTH-2]};
        trial     = {root_q, 2'b01};
        ge        = rem_sh >= trial;
        root_sh   = {root_q, ge};
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        root_d    = root_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        residue_d = residue_q;
        if (state_q == ITER) begin
            op_d    = op_q << 2;
            rem_d   = ge ? rem_sh - trial : rem_sh;
            root_d  = root_sh[H-1:0];
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? UPDATE : ITER;
        end else if (state_q == UPDATE) begin
            result_d  = WORD_LENGTH'(root_q);
            residue_d = WORD_LENGTH'(rem_q);
            state_d   = LOAD;
        end else begin
            op_d    = DataInput;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CW'(H);
            state_d = ITER;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LOAD;
            op_q      <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            residue_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            residue_q <= residue_d;
        end
    end

    assign result  = result_q;
    assign residue = residue_q;
endmodule

// File: tb/tb_square_root.sv
// tb_square_root: directed and random checks of square_root against an arithmetic reference.
module tb_square_root;
    logic        clk;
    logic        reset;
    logic [15:0] DataInput;
    logic [15:0] result;
    logic [15:0] residue;
    int checks = 0;
    int failures = 0;

    square_root #(.WORD_LENGTH(16)) dut (
        .clk(clk), .reset(reset), .DataInput(DataInput), .result(result), .residue(residue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int isqrt(int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_root(string tag, int n);
        int r;
        r = isqrt(n);
        check({tag, "_result"}, {16'd0, result}, r);
        check({tag, "_residue"}, {16'd0, residue}, n - r * r);
    endtask

    // Next edge must be a LOAD edge; after ten edges the new outputs are visible.
    task automatic run_period(string tag, int n);
        DataInput = 16'(n);
        repeat (10) tick();
        expect_root(tag, n);
    endtask

    initial begin
        int n, r;
        reset = 1'b0;
        DataInput = 16'd127;
        #12;
        check("reset_result", {16'd0, result}, 0);
        check("reset_residue", {16'd0, residue}, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("pre_update_result", {16'd0, result}, 0);
            check("pre_update_residue", {16'd0, residue}, 0);
        end
        tick();
        check("first_result", {16'd0, result}, 11);
        check("first_residue", {16'd0, residue}, 6);
        run_period("stable127", 127);
        run_period("stable127b", 127);
        run_period("zero", 0);
        run_period("sq144", 144);
        run_period("max", 65535);
        check("max_residue_const", {16'd0, residue}, 510);
        run_period("one", 1);

        DataInput = 16'd127;
        repeat (4) tick();
        DataInput = 16'd144;
        repeat (6) tick();
        check("midchange_result", {16'd0, result}, 11);
        check("midchange_residue", {16'd0, residue}, 6);
        run_period("after_change", 144);

        DataInput = 16'd200;
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        check("async_result", {16'd0, result}, 0);
        check("async_residue", {16'd0, residue}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (9) tick();
        check("post_reset_hold", {16'd0, result}, 0);
        tick();
        expect_root("post_reset", 200);

        for (int k = 0; k < 40; k++) begin
            n = int'($urandom_range(0, 65535));
            run_period("rand", n);
            r = int'(result);
            check("rand_bound", {31'd0, (r * r <= n) && (n < (r + 1) * (r + 1))}, 1);
            check("rand_upper", {24'd0, result[15:8]}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
